// File: rtl/miniproc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : miniproc_pkg
//  Description : Shared encodings for the memory port arbiter (FSM states,
//                owner ids, default memory latency).
//  Revision    : 1.0 - initial release
// ============================================================================
package miniproc_pkg;

  // Arbiter FSM states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Access owner ids
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DT = 1'b1;

  // Default memory read latency in cycles (legal 1..7)
  localparam int DEF_MEM_LAT = 2;

  // Width of the latency counter
  localparam int CNT_W = 3;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Fetch port, data port and memory pins of the arbiter.
//                slave  = arbiter side, master = requesters + memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;

  // Data port
  logic              dt_req;
  logic              dt_we;
  logic [ADDR_W-1:0] dt_addr;
  logic [DATA_W-1:0] dt_wdata;
  logic [DATA_W-1:0] dt_rdata;
  logic              dt_done;

  // Memory pins
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Status
  logic              busy;

  modport slave (
    input  if_req, if_addr,
    input  dt_req, dt_we, dt_addr, dt_wdata,
    input  mem_rdata,
    output if_rdata, if_done,
    output dt_rdata, dt_done,
    output mem_addr, mem_wr, mem_wdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output dt_req, dt_we, dt_addr, dt_wdata,
    output mem_rdata,
    input  if_rdata, if_done,
    input  dt_rdata, dt_done,
    input  mem_addr, mem_wr, mem_wdata,
    input  busy
  );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick2
//  Description : Combinational two-requester round-robin picker. On a tie the
//                requester that was not granted last wins.
//                req_a maps to id OWN_IF, req_b maps to id OWN_DT.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
  import miniproc_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_id
);

  // Single requester wins outright; a tie goes to the one not granted last
  always_comb begin
    gnt_valid = req_a | req_b;
    gnt_id    = OWN_IF;
    if (req_a && req_b) begin
      gnt_id = ~last;
    end else if (req_b) begin
      gnt_id = OWN_DT;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares a single-port memory between the fetch port (IF) and
//                the data port (DT). Round-robin on ties, latches the granted
//                request, times the fixed read latency and returns a one-cycle
//                done pulse to the owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import miniproc_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  // Counter value on the last ACCESS cycle (memory data valid)
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                owner;
  logic                last_gnt;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   dt_rdata_q;

  logic                gnt_valid;
  logic                gnt_id;
  logic                acc_last;

  rr_pick2 u_pick (
    .req_a     (bus.if_req),
    .req_b     (bus.dt_req),
    .last      (last_gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign acc_last = (cnt == LAST_CNT);

  // State register, request latches, latency counter and read-data capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      owner      <= OWN_IF;
      last_gnt   <= OWN_DT;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dt_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            owner    <= gnt_id;
            last_gnt <= gnt_id;
            cnt      <= '0;
            if (gnt_id == OWN_DT) begin
              addr_q  <= bus.dt_addr;
              we_q    <= bus.dt_we;
              wdata_q <= bus.dt_wdata;
            end else begin
              // Fetches are always reads
              addr_q  <= bus.if_addr;
              we_q    <= 1'b0;
              wdata_q <= '0;
            end
          end
        end
        ST_ACCESS: begin
          cnt <= cnt + 1'b1;
          // Stores leave the owner's read-data register untouched
          if (acc_last && !we_q) begin
            if (owner == OWN_DT) begin
              dt_rdata_q <= bus.mem_rdata;
            end else begin
              if_rdata_q <= bus.mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic; a dropped request never aborts an access in flight
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (gnt_valid) state_nxt = ST_ACCESS;
      ST_ACCESS: if (acc_last)  state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Memory pins and port outputs decoded from the current state
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wr    = 1'b0;
    bus.if_done   = 1'b0;
    bus.dt_done   = 1'b0;
    if (state == ST_ACCESS) begin
      bus.mem_addr  = addr_q;
      bus.mem_wdata = wdata_q;
      // Write strobe only on the first ACCESS cycle
      bus.mem_wr    = we_q && (cnt == '0);
    end
    if (state == ST_DONE) begin
      bus.if_done = (owner == OWN_IF);
      bus.dt_done = (owner == OWN_DT);
    end
    bus.if_rdata = if_rdata_q;
    bus.dt_rdata = dt_rdata_q;
    bus.busy     = (state != ST_IDLE);
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data memory between two requesters: the fetch port (IF, driven by the control unit's fetch sequence) and the data port (DT, load/store).
- Replaces the hard-coded memory wait counting in the control unit with a request/done handshake.
- Owns the memory address/write/data pins.
- Arbitrates round-robin on ties and times the fixed memory read latency.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from address presented to mem_rdata valid (legal 1..7).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (reset==0 at a posedge resets the block).
- if_req  in  1  fetch request; level, held until if_done.
- if_addr  in  ADDR_W  fetch address; stable while if_req=1.
- if_rdata  out  DATA_W  fetched word; valid while if_done=1.
- if_done  out  1  one-cycle completion pulse for fetch.
- dt_req  in  1  data request; level, held until dt_done.
- dt_we  in  1  1=store, 0=load.
- dt_addr  in  ADDR_W  data address.
- dt_wdata  in  DATA_W  store data.
- dt_rdata  out  DATA_W  load data; valid while dt_done=1.
- dt_done  out  1  one-cycle completion pulse for data.
- mem_addr  out  ADDR_W  memory address.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  1 while in ACCESS or DONE.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, cnt=0, last_gnt=DT (so IF wins the first tie). All outputs 0. Any in-flight access is abandoned; mem_wr is 0 from that edge on, and no done pulse is emitted.
- States: IDLE, ACCESS, DONE (2-bit encoding).
- IDLE:
  - no req: stay IDLE.
  - one req: grant it.
  - both: grant the port not equal to last_gnt.
  - On the grant edge: latch owner, addr, we, wdata into internal registers; last_gnt<=owner; cnt<=0; state<=ACCESS.
- ACCESS:
  - mem_addr = latched addr.
  - mem_wdata = latched wdata.
  - mem_wr=1 only when cnt==0 and the latched we=1.
  - cnt increments each cycle.
  - At cnt==MEM_LAT-1: capture mem_rdata into the owner's rdata register (loads and fetches only; a store leaves rdata unchanged); state<=DONE.
- DONE: owner's done=1 for exactly this cycle; state<=IDLE.
- Requester drops req on the edge after its done.
- Latency: req sampled in IDLE at cycle 0 -> done high in cycle MEM_LAT+1.
- One IDLE bubble always exists between consecutive accesses.
- A req that falls mid-access does not abort it; the access completes and done still pulses.
- Input changes to addr/we/wdata after the grant have no effect (latched).
- rdata outputs hold their last captured value; they are meaningful only while done=1.
- if_done and dt_done are never high in the same cycle.
- mem_addr and mem_wdata are 0 in IDLE.
- busy = (state!=IDLE).
- cnt is 3 bits wide. MEM_LAT=1 makes ACCESS last exactly one cycle.

Decomposition:
- Shared package (miniproc_pkg):
  - state encodings ST_IDLE/ST_ACCESS/ST_DONE.
  - owner encodings OWN_IF=1'b0, OWN_DT=1'b1.
  - default MEM_LAT.
- One natural sub-module: rr_pick2. A combinational two-requester round-robin picker with inputs req_a, req_b, last and outputs gnt_valid, gnt_id.
- Counter and latches stay in the top.

Test Plan:
- Single fetch, MEM_LAT=2: if_req=1, if_addr=0x10, memory returns 0xDEADBEEF -> mem_addr=0x10 in cycles 1-2, if_done=1 only in cycle 3 with if_rdata=0xDEADBEEF, mem_wr=0 throughout.
- Store: dt_req=1, dt_we=1, dt_addr=0x40, dt_wdata=0x12345678 -> mem_wr=1 only in cycle 1, mem_addr=0x40, mem_wdata=0x12345678; dt_done in cycle 3; if_done stays 0.
- Tie after reset: if_req and dt_req both high at cycle 0 -> IF served first (if_done cycle 3). IDLE in cycle 4. DT granted at the cycle-4 edge, dt_done in cycle 7. Next tie goes to IF again.
- Sustained contention: both reqs re-asserted after every done, 6 accesses -> grant order IF,DT,IF,DT,IF,DT; no port is starved.
- Reset mid-access: reset=0 in cycle 2 of a store -> from that edge busy=0, mem_wr=0, no dt_done. After reset=1, a new if_req is served normally with done at +3.
- MEM_LAT=1 build: single load from 0x8 returning 0xA5 -> dt_done in cycle 2 with dt_rdata=0xA5.
